// File: rtl/word_reader_ctrl.sv
// word_reader_ctrl: sequencing controller for the column-based letter readers.
// It frames letters into words from the 3-bit column stream and the readers'
// hit outputs, buffers the letter codes, and reports a completed word or an error.
// Optional build macro WORD_READER_TIMEOUT_EN: abort a letter that runs to
// MAX_COLS non-blank columns without a hit. Without it, the column count saturates.
module word_reader_ctrl #(
  parameter int NUM_LETTERS = 4,
  parameter int CODE_W      = 2,
  parameter int MAX_LETTERS = 4,
  parameter int LEN_W       = 3,
  parameter int MAX_COLS    = 6
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [2:0]                      bits,
  input  logic [NUM_LETTERS-1:0]          letter_hit,
  output logic                            reader_restart,
  output logic                            busy,
  output logic                            word_valid,
  output logic [LEN_W-1:0]                word_len,
  output logic [MAX_LETTERS*CODE_W-1:0]   word_codes,
  output logic                            word_error
);

  localparam int COL_W = $clog2(MAX_COLS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LETTER = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_WEC    = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]                    state, state_nxt;
  logic [LEN_W-1:0]              acc_len, acc_len_nxt;
  logic [MAX_LETTERS*CODE_W-1:0] acc_codes, acc_codes_nxt;
  logic [COL_W-1:0]              col_cnt, col_cnt_nxt;
  logic                          load_word;
  logic                          take_hit;
  logic                          hit_any;
  logic [CODE_W-1:0]             hit_code;

  // Lowest-index reader wins when several report a hit on the same column.
  function automatic logic [CODE_W-1:0] lowest_hit(input logic [NUM_LETTERS-1:0] hit);
    lowest_hit = '0;
    for (int i = NUM_LETTERS - 1; i >= 0; i--) begin
      if (hit[i]) lowest_hit = CODE_W'(i);
    end
  endfunction

  assign hit_any  = |letter_hit;
  assign hit_code = lowest_hit(letter_hit);

  // Next-state and accumulator update; only enabled edges advance, except ERROR.
  always_comb begin
    state_nxt     = state;
    acc_len_nxt   = acc_len;
    acc_codes_nxt = acc_codes;
    col_cnt_nxt   = col_cnt;
    load_word     = 1'b0;
    take_hit      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && bits == 3'b000) begin
          state_nxt   = S_LETTER;
          col_cnt_nxt = '0;
        end
      end
      S_LETTER: begin
        if (enable) begin
          if (hit_any) begin
            take_hit = 1'b1;
          end else if (bits != 3'b000) begin
`ifdef WORD_READER_TIMEOUT_EN
            if (col_cnt == COL_W'(MAX_COLS - 1)) state_nxt = S_ERROR;
            else                                  col_cnt_nxt = col_cnt + COL_W'(1);
`else
            if (col_cnt != COL_W'(MAX_COLS)) col_cnt_nxt = col_cnt + COL_W'(1);
`endif
          end else if (col_cnt != '0) begin
            // Blank after letter columns with no reader match: unknown letter.
            state_nxt = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (enable) state_nxt = (bits == 3'b000) ? S_WEC : S_ERROR;
      end
      S_WEC: begin
        if (enable) begin
          if (bits == 3'b000) begin
            load_word     = 1'b1;
            state_nxt     = S_IDLE;
            acc_len_nxt   = '0;
            acc_codes_nxt = '0;
            col_cnt_nxt   = '0;
          end else if (hit_any) begin
            take_hit = 1'b1;
          end else begin
            // This column is already the first one of the next letter.
            state_nxt   = S_LETTER;
            col_cnt_nxt = COL_W'(1);
          end
        end
      end
      S_ERROR: begin
        state_nxt     = S_IDLE;
        acc_len_nxt   = '0;
        acc_codes_nxt = '0;
        col_cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (take_hit) begin
      if (acc_len == LEN_W'(MAX_LETTERS)) begin
        state_nxt = S_ERROR;
      end else begin
        for (int k = 0; k < MAX_LETTERS; k++) begin
          if (acc_len == LEN_W'(k)) acc_codes_nxt[k*CODE_W +: CODE_W] = hit_code;
        end
        acc_len_nxt = acc_len + LEN_W'(1);
        col_cnt_nxt = '0;
        state_nxt   = S_GAP;
      end
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      acc_len        <= '0;
      acc_codes      <= '0;
      col_cnt        <= '0;
      reader_restart <= 1'b1;
      busy           <= 1'b0;
      word_valid     <= 1'b0;
      word_error     <= 1'b0;
      word_len       <= '0;
      word_codes     <= '0;
    end else begin
      state          <= state_nxt;
      acc_len        <= acc_len_nxt;
      acc_codes      <= acc_codes_nxt;
      col_cnt        <= col_cnt_nxt;
      reader_restart <= (state_nxt == S_IDLE) || (state_nxt == S_GAP) || (state_nxt == S_ERROR);
      busy           <= (state_nxt != S_IDLE);
      word_valid     <= load_word;
      word_error     <= (state_nxt == S_ERROR);
      if (load_word) begin
        word_len   <= acc_len;
        word_codes <= acc_codes;
      end
    end
  end

endmodule
